mem_port_arbiter: RTL and testbench

//  Shares the single unified memory port between two masters: port C (multi-cycle

---
 rtl/mem_port_arbiter_if.sv | 59 +++++
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - core/loader request ports and memory-side signals of mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [STRB_W-1:0] c_wstrb;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;
    logic              c_err;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic [STRB_W-1:0] l_wstrb;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;
    logic              l_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_wstrb,
        output c_gnt, c_rvalid, c_rdata, c_err,
        input  l_req, l_we, l_addr, l_wdata, l_wstrb,
        output l_gnt, l_rvalid, l_rdata, l_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rvalid, mem_rdata,
        output busy, owner
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_wstrb,
        input  c_gnt, c_rvalid, c_rdata, c_err,
        output l_req, l_we, l_addr, l_wdata, l_wstrb,
        input  l_gnt, l_rvalid, l_rdata, l_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rvalid, mem_rdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between core (C) and loader (L)
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              resetn,
    mem_port_arbiter_if.slave bus
);
    localparam int               STRB_W   = DATA_W / 8;
    localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } state_t;

    state_t            state_q,     state_d;
    logic              last_q,      last_d;
    logic              owner_q,     owner_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              c_rvalid_q,  c_rvalid_d;
    logic              l_rvalid_q,  l_rvalid_d;
    logic [DATA_W-1:0] c_rdata_q,   c_rdata_d;
    logic [DATA_W-1:0] l_rdata_q,   l_rdata_d;
    logic              c_err_q,     c_err_d;
    logic              l_err_q,     l_err_d;

    logic              winner;
    logic              idle_arb;
    logic [CNT_W-1:0]  cnt_inc;
    logic              done;
    logic              timed_out;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        if (bus.c_req && bus.l_req) begin
            winner = ~last_q;
        end else begin
            winner = ~bus.c_req;
        end
    end

    assign idle_arb  = resetn && (state_q == IDLE);
    assign bus.c_gnt = idle_arb && bus.c_req && !winner;
    assign bus.l_gnt = idle_arb && bus.l_req && winner;
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        cnt_d       = cnt_q;
        c_rvalid_d  = 1'b0;
        l_rvalid_d  = 1'b0;
        c_rdata_d   = c_rdata_q;
        l_rdata_d   = l_rdata_q;
        c_err_d     = c_err_q;
        l_err_d     = l_err_q;
        done        = 1'b0;
        timed_out   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.c_req || bus.l_req) begin
                    state_d     = ISSUE;
                    owner_d     = winner;
                    last_d      = winner;
                    cnt_d       = '0;
                    mem_we_d    = winner ? bus.l_we    : bus.c_we;
                    mem_addr_d  = winner ? bus.l_addr  : bus.c_addr;
                    mem_wdata_d = winner ? bus.l_wdata : bus.c_wdata;
                    mem_wstrb_d = winner ? bus.l_wstrb : bus.c_wstrb;
                end
            end
            ISSUE: begin
                cnt_d = cnt_inc;
                if (bus.mem_ready && bus.mem_rvalid) begin
                    done = 1'b1;
                end else begin
                    if (bus.mem_ready) begin
                        state_d = WAIT_RESP;
                    end
                    timed_out = TO_EN && (cnt_inc == TO_LIMIT);
                end
            end
            WAIT_RESP: begin
                cnt_d = cnt_inc;
                if (bus.mem_rvalid) begin
                    done = 1'b1;
                end else begin
                    timed_out = TO_EN && (cnt_inc == TO_LIMIT);
                end
            end
            default: state_d = IDLE;
        endcase

        // A genuine response in the same cycle as the limit still completes normally.
        if (done || timed_out) begin
            state_d = IDLE;
            if (owner_q) begin
                l_rvalid_d = 1'b1;
                l_rdata_d  = done ? bus.mem_rdata : '0;
                l_err_d    = timed_out;
            end else begin
                c_rvalid_d = 1'b1;
                c_rdata_d  = done ? bus.mem_rdata : '0;
                c_err_d    = timed_out;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            cnt_q       <= '0;
            c_rvalid_q  <= 1'b0;
            l_rvalid_q  <= 1'b0;
            c_rdata_q   <= '0;
            l_rdata_q   <= '0;
            c_err_q     <= 1'b0;
            l_err_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            cnt_q       <= cnt_d;
            c_rvalid_q  <= c_rvalid_d;
            l_rvalid_q  <= l_rvalid_d;
            c_rdata_q   <= c_rdata_d;
            l_rdata_q   <= l_rdata_d;
            c_err_q     <= c_err_d;
            l_err_q     <= l_err_d;
        end
    end

    assign bus.mem_req   = (state_q == ISSUE);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.c_rvalid  = c_rvalid_q;
    assign bus.l_rvalid  = l_rvalid_q;
    assign bus.c_rdata   = c_rdata_q;
    assign bus.l_rdata   = l_rdata_q;
    assign bus.c_err     = c_err_q;
    assign bus.l_err     = l_err_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    bit          gnt_log[$];
    int          gnt_count = 0;
    bit          model_last = 1'b1;
    int          n_checks = 0;
    int          n_fails = 0;

    int          ready_dly = 0;
    int          resp_dly = 1;
    logic [31:0] resp_data = '0;
    bit          exp_to = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: ready after ready_dly cycles, response resp_dly cycles after ready.
    initial begin : mem_model
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (resetn && bus.mem_req) begin
                repeat (ready_dly) @(negedge clk);
                bus.mem_ready = 1'b1;
                if (resp_dly == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = resp_data;
                end else begin
                    @(negedge clk);
                    bus.mem_ready = 1'b0;
                    repeat (resp_dly - 1) @(negedge clk);
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = resp_data;
                end
            end
        end
    end

    always begin : monitor
        exp_t e;
        bit   w;
        @(negedge clk);
        #2;
        if (!resetn) begin
            sb.delete();
            model_last = 1'b1;
        end else begin
            if (bus.c_rvalid || bus.l_rvalid) begin
                check("sb_nonempty_on_rvalid", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rvalid_port", {bus.c_rvalid, bus.l_rvalid}, e.port ? 2'b01 : 2'b10);
                    check("owner", bus.owner, e.port);
                    check("rdata", e.port ? bus.l_rdata : bus.c_rdata, e.rdata);
                    check("err", e.port ? bus.l_err : bus.c_err, e.err);
                end
            end
            if (bus.mem_req) begin
                check("sb_nonempty_on_mem_req", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    check("mem_addr", bus.mem_addr, sb[0].addr);
                    check("mem_we", bus.mem_we, sb[0].we);
                    check("mem_wdata", bus.mem_wdata, sb[0].wdata);
                    check("mem_wstrb", bus.mem_wstrb, sb[0].wstrb);
                end
            end
            if (bus.c_gnt || bus.l_gnt) begin
                check("single_gnt", bus.c_gnt && bus.l_gnt, 0);
                w = (bus.c_req && bus.l_req) ? !model_last : bus.l_req;
                check("gnt_winner", bus.l_gnt, w);
                w = bus.l_gnt;
                model_last = w;
                e.port  = w;
                e.we    = w ? bus.l_we : bus.c_we;
                e.addr  = w ? bus.l_addr : bus.c_addr;
                e.wdata = w ? bus.l_wdata : bus.c_wdata;
                e.wstrb = w ? bus.l_wstrb : bus.c_wstrb;
                e.rdata = exp_to ? 32'h0 : resp_data;
                e.err   = exp_to;
                sb.push_back(e);
                gnt_log.push_back(w);
                gnt_count++;
            end
        end
    end

    task automatic drive(input bit port, input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
        if (port) begin
            bus.l_req = req; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wdata; bus.l_wstrb = wstrb;
        end else begin
            bus.c_req = req; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata; bus.c_wstrb = wstrb;
        end
    endtask

    task automatic run_txn(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output int busy_cyc, output int req_cyc);
        int n;
        @(negedge clk);
        drive(port, 1'b1, we, addr, wdata, wstrb);
        #2;
        n = 0;
        while (!(port ? bus.l_gnt : bus.c_gnt) && n < 50) begin
            @(negedge clk); #2; n++;
        end
        check("gnt_seen", n < 50, 1);
        @(negedge clk); #2;
        check("gnt_one_cycle", port ? bus.l_gnt : bus.c_gnt, 0);
        drive(port, 1'b0, we, addr, wdata, wstrb);
        busy_cyc = 0; req_cyc = 0; n = 0;
        while (!(port ? bus.l_rvalid : bus.c_rvalid) && n < 100) begin
            busy_cyc += int'(bus.busy);
            req_cyc  += int'(bus.mem_req);
            @(negedge clk); #2; n++;
        end
        check("rvalid_seen", n < 100, 1);
        @(negedge clk); #2;
        check("rvalid_one_cycle", port ? bus.l_rvalid : bus.c_rvalid, 0);
    endtask

    initial begin : stimulus
        int busy_cyc, req_cyc, start, n, c_wins;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        bus.c_req = 1'b1;
        #2;
        check("rst_c_gnt", bus.c_gnt, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_owner", bus.owner, 0);
        check("rst_rvalid", {bus.c_rvalid, bus.l_rvalid}, 0);
        check("rst_err", {bus.c_err, bus.l_err}, 0);
        check("rst_c_rdata", bus.c_rdata, 0);
        check("rst_mem_attr", {bus.mem_we, bus.mem_addr, bus.mem_wstrb}, 0);
        bus.c_req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        ready_dly = 0; resp_dly = 2; resp_data = 32'hDEADBEEF; exp_to = 1'b0;
        run_txn(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, busy_cyc, req_cyc);
        check("t1_busy_cycles", busy_cyc, 3);
        check("t1_req_cycles", req_cyc, 1);

        ready_dly = 5; resp_dly = 1; resp_data = 32'hA5A5A5A5;
        run_txn(1'b1, 1'b1, 32'h40, 32'h12345678, 4'h3, busy_cyc, req_cyc);
        check("t3_busy_cycles", busy_cyc, 7);
        check("t3_req_cycles", req_cyc, 6);

        ready_dly = 0; resp_dly = 0; resp_data = 32'h0BADF00D;
        run_txn(1'b0, 1'b0, 32'h200, 32'h0, 4'h0, busy_cyc, req_cyc);
        check("t4_busy_cycles", busy_cyc, 1);

        ready_dly = 0; resp_dly = 1; resp_data = 32'h5555AAAA;
        start = gnt_count;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b1, 32'h304, 32'hCAFE0001, 4'hF);
        n = 0;
        do begin @(negedge clk); #3; n++; end while (gnt_count < start + 4 && n < 200);
        @(negedge clk);
        bus.c_req = 1'b0; bus.l_req = 1'b0;
        n = 0;
        do begin @(negedge clk); #3; n++; end while ((bus.busy || sb.size() != 0) && n < 50);
        check("t2_drained", n < 50, 1);
        check("t2_grant_count", gnt_count - start, 4);
        c_wins = 0;
        for (int i = start; i < start + 4 && i < gnt_log.size(); i++) begin
            c_wins += int'(!gnt_log[i]);
            if (i > start) check("t2_alternate", gnt_log[i] != gnt_log[i-1], 1);
        end
        check("t2_c_share", c_wins, 2);

        ready_dly = 0; resp_dly = 14; resp_data = 32'hFFFF0000; exp_to = 1'b1;
        run_txn(1'b0, 1'b0, 32'h500, 32'h0, 4'h0, busy_cyc, req_cyc);
        check("t5_timeout_cycles", busy_cyc, TO);
        exp_to = 1'b0;
        repeat (20) @(negedge clk);
        resp_dly = 1; resp_data = 32'h600DCAFE;
        run_txn(1'b0, 1'b0, 32'h504, 32'h0, 4'h0, busy_cyc, req_cyc);
        check("t5_after_busy", busy_cyc, 2);

        ready_dly = 0; resp_dly = 20; resp_data = 32'h77777777;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 32'h700, 32'h0, 4'h0);
        @(negedge clk);
        bus.c_req = 1'b0;
        n = 0;
        #2;
        while (!(bus.busy && !bus.mem_req) && n < 20) begin @(negedge clk); #2; n++; end
        check("t6_in_wait", n < 20, 1);
        @(negedge clk);
        resetn = 1'b0;
        bus.c_req = 1'b1;
        #1;
        check("t6_mem_req", bus.mem_req, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_rvalid", {bus.c_rvalid, bus.l_rvalid}, 0);
        check("t6_gnt_in_reset", bus.c_gnt, 0);
        @(negedge clk);
        bus.c_req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (25) @(negedge clk);
        check("t6_idle_after_late_rvalid", bus.busy, 0);
        resp_dly = 1; resp_data = 32'h13579BDF;
        start = gnt_count;
        drive(1'b0, 1'b1, 1'b0, 32'h800, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h900, 32'h0, 4'h0);
        #2;
        check("t6_first_gnt_c", {bus.c_gnt, bus.l_gnt}, 2'b10);
        @(negedge clk);
        bus.c_req = 1'b0; bus.l_req = 1'b0;
        repeat (10) @(negedge clk);
        #3;
        check("t6_single_txn", gnt_count - start, 1);
        check("t6_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule
